// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in over
// a window of GATE_CYCLES clocks and publishes the count with a strobe.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             ovf,
  output logic             no_sig
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [GW-1:0]    r_gate_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_sat;
  logic             r_busy;
  logic [CNT_W-1:0] r_freq;
  logic             r_valid;
  logic             r_ovf;
  logic             r_no_sig;
  logic             w_edge;

  assign w_edge = r_s2 & ~r_s3;

  // synchronizer runs in every state so stale edges never leak into a window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_busy     <= 1'b0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_no_sig   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start | continuous) begin
            r_state    <= S_GATE;
            r_busy     <= 1'b1;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
          end
        end
        S_GATE: begin
          r_gate_cnt <= r_gate_cnt + 1'b1;
          if (w_edge) begin
            if (r_edge_cnt == MAX) begin
              r_sat <= 1'b1;
            end else begin
              r_edge_cnt <= r_edge_cnt + 1'b1;
            end
          end
          if (r_gate_cnt == LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_freq     <= r_edge_cnt;
          r_valid    <= 1'b1;
          r_ovf      <= r_sat;
          r_no_sig   <= (r_edge_cnt == '0);
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          if (continuous) begin
            r_state <= S_GATE;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign freq       = r_freq;
  assign freq_valid = r_valid;
  assign ovf        = r_ovf;
  assign no_sig     = r_no_sig;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: two instances (8-bit and 4-bit
// counters), 100-cycle gate, directed square-wave stimulus.
module tb_freq_meter;

  typedef struct {
    int f;
    int o;
    int n;
    int c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig_a = 1'b0;
  logic       sig_b = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       cont_a = 1'b0;
  logic       busy_a, busy_b;
  logic [7:0] freq_a;
  logic [3:0] freq_b;
  logic       va, vb;
  logic       ovf_a, ovf_b;
  logic       ns_a, ns_b;

  int per_a = 6;
  int per_b = 0;
  int ph_a = 0;
  int ph_b = 0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int acc;

  exp_t qa[$];
  exp_t qb[$];

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_a),
    .start(start_a), .continuous(cont_a),
    .busy(busy_a), .freq(freq_a), .freq_valid(va),
    .ovf(ovf_a), .no_sig(ns_a)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_b),
    .start(start_b), .continuous(1'b0),
    .busy(busy_b), .freq(freq_b), .freq_valid(vb),
    .ovf(ovf_b), .no_sig(ns_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (per_a == 0) begin
      ph_a = 0;
      sig_a = 1'b0;
    end else begin
      sig_a = (ph_a < per_a / 2);
      ph_a = (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
    end
    if (per_b == 0) begin
      ph_b = 0;
      sig_b = 1'b0;
    end else begin
      sig_b = (ph_b < per_b / 2);
      ph_b = (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
    end
  end

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // scoreboard monitors: pop one expectation per strobe
  always @(negedge clk) begin
    exp_t e;
    if (va) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_valid", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("a_freq", int'(freq_a), e.f);
        chk("a_ovf", int'(ovf_a), e.o);
        chk("a_no_sig", int'(ns_a), e.n);
        chk("a_valid_cycle", cyc, e.c);
      end
    end
    if (vb) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_valid", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_freq", int'(freq_b), e.f);
        chk("b_ovf", int'(ovf_b), e.o);
        chk("b_no_sig", int'(ns_b), e.n);
        chk("b_valid_cycle", cyc, e.c);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset with toggling input
    tick(8);
    chk("rst_freq_a", int'(freq_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_valid_a", int'(va), 0);
    chk("rst_ovf_a", int'(ovf_a), 0);
    chk("rst_nosig_a", int'(ns_a), 0);
    chk("rst_freq_b", int'(freq_b), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    rst = 1'b0;
    tick(20);
    chk("idle_busy_a", int'(busy_a), 0);
    chk("idle_freq_a", int'(freq_a), 0);

    // single shot, period 10
    per_a = 10;
    tick(5);
    qa.push_back('{10, 0, 0, cyc + 102});
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    chk("busy_after_start", int'(busy_a), 1);
    tick(110);
    chk("idle_after_shot", int'(busy_a), 0);

    // held low
    per_a = 0;
    tick(5);
    qa.push_back('{0, 0, 1, cyc + 102});
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(110);
    chk("idle_after_nosig", int'(busy_a), 0);
    chk("hold_nosig", int'(ns_a), 1);

    // saturation on 4-bit instance
    per_b = 4;
    tick(5);
    qb.push_back('{15, 1, 0, cyc + 102});
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    tick(110);
    chk("b_idle_after_sat", int'(busy_b), 0);
    chk("b_hold_freq", int'(freq_b), 15);

    // continuous, period 20, drop mid third window
    per_a = 20;
    tick(5);
    acc = cyc + 1;
    for (int k = 1; k <= 3; k++) qa.push_back('{5, 0, 0, acc + 101 * k});
    cont_a = 1'b1;
    tick(1);
    tick(251);
    chk("cont_busy_mid", int'(busy_a), 1);
    cont_a = 1'b0;
    tick(60);
    chk("cont_idle_after_drop", int'(busy_a), 0);

    // start while busy is ignored
    per_a = 10;
    tick(5);
    qa.push_back('{10, 0, 0, cyc + 102});
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(30);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(200);
    chk("no_extra_window", int'(busy_a), 0);

    // reset mid-window at gate_cnt = 50
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(50);
    rst = 1'b1;
    tick(1);
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_freq_a", int'(freq_a), 0);
    chk("midrst_freq_b", int'(freq_b), 0);
    chk("midrst_ovf_b", int'(ovf_b), 0);
    rst = 1'b0;
    tick(130);
    chk("post_rst_idle", int'(busy_a), 0);

    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
